// File: rtl/par2serial.sv
// par2serial: parallel-to-slice-serial width down-converter.
// A DIN_W-bit word is captured on every LOAD edge (slice counter == 0).
// It is then emitted as RATIO = DIN_W/DOUT_W consecutive DOUT_W-bit slices,
// one per clock. Output order is MSB-first or LSB-first. The design is
// free-running, with no handshake. The output is registered, so there is
// no combinational path from datain to dataout.
module par2serial #(
  parameter int DIN_W     = 16,
  parameter int DOUT_W    = 8,
  parameter int MSB_FIRST = 1
) (
  output logic [DOUT_W-1:0] dataout,
  input  logic [DIN_W-1:0]  datain,
  input  logic              rst,
  input  logic              clk
);

  localparam int RATIO = DIN_W / DOUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // A word that does not split evenly into slices cannot be serialised.
  if (((DIN_W % DOUT_W) != 0) || (DIN_W < DOUT_W)) begin : g_bad_width
    $error("par2serial: DIN_W must be a positive integer multiple of DOUT_W");
  end

  // Return slice number k of a word, counted in emission order.
  function automatic logic [DOUT_W-1:0] slice_of(input logic [DIN_W-1:0] word,
                                                 input int               k);
    int idx;
    idx = (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
    return word[idx*DOUT_W +: DOUT_W];
  endfunction

  logic [CNT_W-1:0]  r_cnt;
  logic [DIN_W-1:0]  r_shadow;
  logic [DOUT_W-1:0] r_dataout;

  logic              w_load;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DOUT_W-1:0] w_slice;

  // Next counter value, load strobe and the slice to present on the next edge.
  always_comb begin
    w_load    = 1'b0;
    w_cnt_nxt = CNT_ZERO;
    w_slice   = {DOUT_W{1'b0}};
    if (r_cnt == CNT_ZERO) begin
      // The first slice comes straight from datain; later slices come from the shadow copy.
      w_load  = 1'b1;
      w_slice = slice_of(datain, 0);
    end else begin
      w_load  = 1'b0;
      w_slice = slice_of(r_shadow, int'(r_cnt));
    end
    if (r_cnt == CNT_LAST) begin
      w_cnt_nxt = CNT_ZERO;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Slice counter, shadow word and output register. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= CNT_ZERO;
      r_shadow  <= {DIN_W{1'b0}};
      r_dataout <= {DOUT_W{1'b0}};
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_dataout <= w_slice;
      if (w_load) begin
        r_shadow <= datain;
      end
    end
  end

  assign dataout = r_dataout;

endmodule

// File: tb/tb_par2serial.sv
// Directed testbench for par2serial.
// Three instances share the same clock, reset and input word:
//   u_dut  : default MSB-first, 16->8
//   u_lsb  : LSB-first, 16->8
//   u_r1   : RATIO==1, 8->8 (a pure register on datain[7:0])
module tb_par2serial;

  logic        clk;
  logic        rst;
  logic [15:0] datain;
  logic [7:0]  dout_msb;
  logic [7:0]  dout_lsb;
  logic [7:0]  dout_r1;

  int vectors;
  int miscompares;

  par2serial #(.DIN_W(16), .DOUT_W(8), .MSB_FIRST(1)) u_dut (
    .dataout (dout_msb),
    .datain  (datain),
    .rst     (rst),
    .clk     (clk)
  );

  par2serial #(.DIN_W(16), .DOUT_W(8), .MSB_FIRST(0)) u_lsb (
    .dataout (dout_lsb),
    .datain  (datain),
    .rst     (rst),
    .clk     (clk)
  );

  par2serial #(.DIN_W(8), .DOUT_W(8), .MSB_FIRST(1)) u_r1 (
    .dataout (dout_r1),
    .datain  (datain[7:0]),
    .rst     (rst),
    .clk     (clk)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed byte against its hand-computed expected value.
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word for two cycles and check both slices on both 16->8 instances.
  task automatic word2(input logic [15:0] w, input string tag);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = w[15:8];
    lo = w[7:0];
    datain = w;
    tick();
    chk({tag, "_msb_hi"}, dout_msb, hi);
    chk({tag, "_lsb_lo"}, dout_lsb, lo);
    chk({tag, "_r1_a"},   dout_r1,  lo);
    tick();
    chk({tag, "_msb_lo"}, dout_msb, lo);
    chk({tag, "_lsb_hi"}, dout_lsb, hi);
    chk({tag, "_r1_b"},   dout_r1,  lo);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    datain      = 16'h3524;

    // 1. Reset held for three edges: all outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_msb", dout_msb, 8'h00);
      chk("reset_lsb", dout_lsb, 8'h00);
      chk("reset_r1",  dout_r1,  8'h00);
    end

    // 2 and 6. First word after release: 35,24 MSB-first and 24,35 LSB-first.
    rst = 1'b0;
    word2(16'h3524, "first");

    // 3. Back-to-back words with no gaps.
    word2(16'h5e81, "w0");
    word2(16'hd609, "w1");
    word2(16'h5663, "w2");
    word2(16'h7b0d, "w3");
    word2(16'h998d, "w4");

    // 4. datain changes during the second-slice cycle and must be ignored.
    datain = 16'h5e81;
    tick();
    chk("hold_msb_hi", dout_msb, 8'h5e);
    chk("hold_lsb_lo", dout_lsb, 8'h81);
    datain = 16'hffff;
    tick();
    chk("hold_msb_lo", dout_msb, 8'h81);
    chk("hold_lsb_hi", dout_lsb, 8'h5e);
    chk("hold_r1",     dout_r1,  8'hff);
    tick();
    chk("next_msb_hi", dout_msb, 8'hff);
    chk("next_lsb_lo", dout_lsb, 8'hff);
    tick();
    chk("next_msb_lo", dout_msb, 8'hff);
    chk("next_lsb_hi", dout_lsb, 8'hff);

    // 5. Reset mid-word discards the remaining slice; the next edge reloads.
    datain = 16'hd609;
    tick();
    chk("mid_msb_d6", dout_msb, 8'hd6);
    chk("mid_lsb_09", dout_lsb, 8'h09);
    rst = 1'b1;
    tick();
    chk("mid_rst_msb", dout_msb, 8'h00);
    chk("mid_rst_lsb", dout_lsb, 8'h00);
    chk("mid_rst_r1",  dout_r1,  8'h00);
    rst    = 1'b0;
    datain = 16'h1234;
    tick();
    chk("reload_msb_hi", dout_msb, 8'h12);
    chk("reload_lsb_lo", dout_lsb, 8'h34);
    chk("reload_r1",     dout_r1,  8'h34);
    datain = 16'habcd;
    tick();
    chk("reload_msb_lo", dout_msb, 8'h34);
    chk("reload_lsb_hi", dout_lsb, 8'h12);
    chk("reload_r1_new", dout_r1,  8'hcd);

    // The next word after the reload is also aligned.
    word2(16'habcd, "post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
